// File: rtl/ndiv_pkg.sv
// Shared definitions for the ndiv restoring divider: FSM state encoding and
// the iteration-counter width helper.
package ndiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold 0..Nsize.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ndiv_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, subtract the divisor if it fits.
module ndiv_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] p,
    input  logic         bit_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] p_new,
    output logic         qbit
);

    logic [W:0] p_ext;
    logic [W:0] diff;

    assign p_ext = {p, bit_in};
    assign diff  = p_ext - {1'b0, d};
    assign qbit  = (p_ext >= {1'b0, d});
    // In the valid range the restored remainder is < d and fits in W bits.
    assign p_new = qbit ? diff[W-1:0] : p_ext[W-1:0];

endmodule

// File: rtl/ndiv.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock. Optional macro NDIV_OVF_DETECT_EN enables divide-by-zero /
// overflow detection (Err flag, fast completion).
module ndiv
    import ndiv_pkg::*;
#(
    parameter int Nsize = 50
) (
    input  logic                 Clk,
    input  logic                 Clr,
    input  logic                 Start,
    input  logic [2*Nsize-1:0]   A,
    input  logic [Nsize-1:0]     B,
    output logic [Nsize-1:0]     Q,
    output logic [Nsize-1:0]     R,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
);

    localparam int             CW   = cnt_width(Nsize);
    localparam logic [CW-1:0]  LAST = CW'(Nsize - 1);

    state_t           state_reg, state_next;
    logic [Nsize-1:0] p_reg, p_next;
    logic [Nsize-1:0] d_reg, d_next;
    logic [Nsize-1:0] b_reg, b_next;
    logic [Nsize-1:0] q_reg, q_next;
    logic [Nsize-1:0] r_reg, r_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             err_reg, err_next;

    logic [Nsize-1:0] step_p;
    logic             step_q;
    logic             ovf;

    ndiv_step #(.W(Nsize)) u_step (
        .p      (p_reg),
        .bit_in (d_reg[Nsize-1]),
        .d      (b_reg),
        .p_new  (step_p),
        .qbit   (step_q)
    );

`ifdef NDIV_OVF_DETECT_EN
    assign ovf = (B == '0) || (A[2*Nsize-1:Nsize] >= B);
`else
    assign ovf = 1'b0;
`endif

    // d_reg holds the unconsumed low dividend bits; quotient bits fill it
    // from the LSB, so after Nsize steps it contains the full quotient.
    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        d_next     = d_reg;
        b_next     = b_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    p_next     = A[2*Nsize-1:Nsize];
                    d_next     = A[Nsize-1:0];
                    b_next     = B;
                    cnt_next   = '0;
                    err_next   = ovf;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (err_reg) begin
                    q_next     = '1;
                    r_next     = '0;
                    state_next = DONE;
                end else begin
                    p_next   = step_p;
                    d_next   = {d_reg[Nsize-2:0], step_q};
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        q_next     = {d_reg[Nsize-2:0], step_q};
                        r_next     = step_p;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            d_reg     <= '0;
            b_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            d_reg     <= d_next;
            b_reg     <= b_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    assign Q    = q_reg;
    assign R    = r_reg;
    assign Busy = (state_reg != IDLE);
    assign Done = (state_reg == DONE);
    assign Err  = err_reg;

endmodule

// File: tb/tb_ndiv.sv
// Self-checking bench for ndiv (Nsize = 8): directed cases plus random valid
// divisions checked against plain integer division.
module tb_ndiv;

    localparam int N = 8;
`ifdef NDIV_OVF_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    logic           Clk = 1'b0;
    logic           Clr = 1'b0;
    logic           Start = 1'b0;
    logic [2*N-1:0] A = '0;
    logic [N-1:0]   B = '0;
    logic [N-1:0]   Q, R;
    logic           Busy, Done, Err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ndiv #(.Nsize(N)) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns the cycle stamp of Done.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input bit mid_start, input string tag, output int done_cyc);
        logic [7:0] eq, er;
        logic       ee;
        bit         chk_qr;
        int         exp_lat, k, extra;
        chk_qr  = 1'b1;
        exp_lat = N;
        ee      = 1'b0;
        eq      = 8'(a / (b == 0 ? 16'd1 : 16'(b)));
        er      = 8'(a % (b == 0 ? 16'd1 : 16'(b)));
        if (b == 0 || a[15:8] >= b) begin
            if (DETECT) begin
                ee = 1'b1; eq = 8'hFF; er = 8'h00; exp_lat = 1;
            end else if (b == 0) begin
                eq = 8'hFF; er = a[7:0];
            end else begin
                chk_qr = 1'b0;
            end
        end
        A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        A = 16'($urandom); B = 8'($urandom);
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        k = 0;
        while (Done !== 1'b1 && k < 40) begin
            Start = (mid_start && k == 3);
            @(negedge Clk);
            k++;
        end
        Start = 1'b0;
        done_cyc = cyc;
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        if (chk_qr) begin
            check({tag, "_q"}, 32'(Q), 32'(eq));
            check({tag, "_r"}, 32'(R), 32'(er));
        end
        check({tag, "_err"}, 32'(Err), 32'(ee));
        @(negedge Clk);
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
        check({tag, "_idle"}, 32'(Busy), 32'd0);
        if (mid_start) begin
            extra = 0;
            repeat (12) begin
                @(negedge Clk);
                if (Done === 1'b1) extra++;
            end
            check({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
        $display("op %s: A=%04h B=%02h -> Q=%02h R=%02h Err=%0b lat=%0d", tag, a, b, Q, R, Err, k);
    endtask

    initial begin
        int dc1, dc2, cnt;
        logic [7:0] rb, rh;

        // reset state
        repeat (2) @(negedge Clk);
        check("rst_q", 32'(Q), 32'd0);
        check("rst_r", 32'(R), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        Clr = 1'b1;
        @(negedge Clk);

        run_op(16'd100, 8'd7, 1'b0, "basic", dc1);
        run_op(16'h7FFF, 8'hFF, 1'b1, "maxdiv", dc1);
        run_op(16'h0012, 8'h00, 1'b0, "divzero", dc1);
        if (DETECT) run_op(16'h0100, 8'h01, 1'b0, "overflow", dc1);

        // abort mid-run with Clr; previous Q/R must vanish at once
        A = 16'd1000; B = 8'd9; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Clr = 1'b0;
        #1;
        check("clr_busy", 32'(Busy), 32'd0);
        check("clr_done", 32'(Done), 32'd0);
        check("clr_q", 32'(Q), 32'd0);
        check("clr_r", 32'(R), 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge Clk);
            if (Done === 1'b1) cnt++;
        end
        check("clr_no_done", 32'(cnt), 32'd0);
        $display("op clr_abort: Done count after release=%0d", cnt);
        run_op(16'd1000, 8'd9, 1'b0, "after_clr", dc1);

        // back-to-back: second Start in the first idle cycle after Done
        run_op(16'd5000, 8'd77, 1'b0, "b2b_1", dc1);
        run_op(16'd3333, 8'd200, 1'b0, "b2b_2", dc2);
        check("b2b_spacing", 32'(dc2 - dc1), 32'(N + 2));

        // random valid-range operations
        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom_range(1, 255));
            rh = 8'($urandom_range(0, int'(rb) - 1));
            run_op({rh, 8'($urandom)}, rb, 1'b0, "rand", dc1);
        end
        if (DETECT) begin
            for (int i = 0; i < 4; i++) begin
                rb = 8'($urandom_range(0, 254));
                rh = 8'($urandom_range(int'(rb), 255));
                run_op({rh, 8'($urandom)}, rb, 1'b0, "rand_ovf", dc1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
